// File: rtl/neo_input_pkg.sv
// -----------------------------------------------------------------------------
// neo_input_pkg
// Shared definitions for the player input path.
//   - Bit indices of the 10-bit active-low player input word.
//   - Width of the per-bit debounce counter.
//   - socd_clean(): releases opposing directions that are pressed together.
//     It is only called when INPUT_SOCD_FILTER_EN is defined.
// -----------------------------------------------------------------------------
package neo_input_pkg;

   localparam int IN_W   = 10;

   localparam int UP     = 0;
   localparam int DOWN   = 1;
   localparam int LEFT   = 2;
   localparam int RIGHT  = 3;
   localparam int BTN_A  = 4;
   localparam int BTN_B  = 5;
   localparam int BTN_C  = 6;
   localparam int BTN_D  = 7;
   localparam int START  = 8;
   localparam int SELECT = 9;

   // Counter width; holds counts up to 15, which bounds DB_COUNT.
   localparam int CNT_W  = 4;

   // Inputs are active-low. A pair that reads "both pressed" is reported as
   // "neither pressed", so downstream logic never sees an impossible direction.
   function automatic logic [IN_W-1:0] socd_clean(input logic [IN_W-1:0] s);
      logic [IN_W-1:0] r;
      r = s;
      if (!s[UP] && !s[DOWN]) begin
         r[UP]   = 1'b1;
         r[DOWN] = 1'b1;
      end
      if (!s[LEFT] && !s[RIGHT]) begin
         r[LEFT]  = 1'b1;
         r[RIGHT] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One raw input pin: 2-flop synchronizer, stable state S and agreement
// counter C. A new level is accepted once it has disagreed with S on
// DB_COUNT consecutive ticks; any cycle in agreement restarts the count.
//
// Ports
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-high reset
//   tick_i    in   one-cycle debounce tick from the shared prescaler
//   raw_i     in   asynchronous raw pin (active-low)
//   stable_o  out  debounced state S (reset 1)
// -----------------------------------------------------------------------------
module debounce_bit
   import neo_input_pkg::*;
#(
   parameter int DB_COUNT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic raw_i,
   output logic stable_o
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DB_COUNT - 1);

   logic             sync1_q, sync2_q;
   logic             s_q, s_d;
   logic [CNT_W-1:0] c_q, c_d;

   // NOTE: every always_comb signal gets a default first so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      s_d = s_q;
      c_d = c_q;
      if (sync2_q == s_q) begin
         c_d = '0;
      end else if (tick_i) begin
         if (c_q == C_LAST) begin
            s_d = sync2_q;
            c_d = '0;
         end else begin
            c_d = c_q + CNT_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; this is what makes sync1 -> sync2 a real two-stage chain.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         s_q     <= 1'b1;
         c_q     <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         s_q     <= s_d;
         c_q     <= c_d;
      end
   end

   assign stable_o = s_q;

endmodule

// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
// Debounces both player input ports (20 active-low pins). A shared prescaler
// produces a one-cycle tick every PRESCALE clocks; each pin runs through its
// own debounce_bit. Debounced words are registered and a change pulse is
// raised in the cycle the registered word changes.
//
// Optional feature: define INPUT_SOCD_FILTER_EN to release opposing
// directions (up+down, left+right) pressed together, applied before the
// output register so the change pulse follows the filtered value.
//
// Parameters
//   PRESCALE  clock cycles per debounce tick (>= 1)
//   DB_COUNT  consecutive disagreeing ticks to accept a change (1..15)
//
// Ports
//   CLK_24M  in   clock, rising edge
//   RESET    in   asynchronous active-high reset
//   P1_RAW   in   [9:0] raw player-1 pins, active-low
//   P2_RAW   in   [9:0] raw player-2 pins, active-low
//   P1_IN    out  [9:0] debounced player-1 word, registered
//   P2_IN    out  [9:0] debounced player-2 word, registered
//   P1_CHG   out  one-cycle pulse when P1_IN changes
//   P2_CHG   out  one-cycle pulse when P2_IN changes
// -----------------------------------------------------------------------------
module input_debounce
   import neo_input_pkg::*;
#(
   parameter int PRESCALE = 24000,
   parameter int DB_COUNT = 4
) (
   input  logic       CLK_24M,
   input  logic       RESET,
   input  logic [9:0] P1_RAW,
   input  logic [9:0] P2_RAW,
   output logic [9:0] P1_IN,
   output logic [9:0] P2_IN,
   output logic       P1_CHG,
   output logic       P2_CHG
);

   localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] ps_q, ps_d;
   logic            tick;

   // With PRESCALE=1 the counter is pinned at 0 and tick is constantly high.
   always_comb begin
      tick = (ps_q == PS_LAST);
      ps_d = tick ? '0 : ps_q + PS_W'(1);
   end

   always_ff @(posedge CLK_24M or posedge RESET) begin
      if (RESET) ps_q <= '0;
      else       ps_q <= ps_d;
   end

   // Bits 9:0 are player 1, bits 19:10 player 2.
   logic [2*IN_W-1:0] raw_all;
   logic [2*IN_W-1:0] s_all;

   assign raw_all = {P2_RAW, P1_RAW};

   for (genvar i = 0; i < 2*IN_W; i++) begin : g_bit
      debounce_bit #(
         .DB_COUNT (DB_COUNT)
      ) u_debounce_bit (
         .clk_i    (CLK_24M),
         .rst_i    (RESET),
         .tick_i   (tick),
         .raw_i    (raw_all[i]),
         .stable_o (s_all[i])
      );
   end

   logic [IN_W-1:0] p1_filt, p2_filt;

`ifdef INPUT_SOCD_FILTER_EN
   assign p1_filt = socd_clean(s_all[IN_W-1:0]);
   assign p2_filt = socd_clean(s_all[2*IN_W-1:IN_W]);
`else
   assign p1_filt = s_all[IN_W-1:0];
   assign p2_filt = s_all[2*IN_W-1:IN_W];
`endif

   logic [IN_W-1:0] p1_in_q, p2_in_q;
   logic            p1_chg_q, p2_chg_q;
   logic            p1_chg_d, p2_chg_d;

   // The pulse is registered alongside the word, so both update on the same edge.
   assign p1_chg_d = (p1_filt != p1_in_q);
   assign p2_chg_d = (p2_filt != p2_in_q);

   always_ff @(posedge CLK_24M or posedge RESET) begin
      if (RESET) begin
         p1_in_q  <= '1;
         p2_in_q  <= '1;
         p1_chg_q <= 1'b0;
         p2_chg_q <= 1'b0;
      end else begin
         p1_in_q  <= p1_filt;
         p2_in_q  <= p2_filt;
         p1_chg_q <= p1_chg_d;
         p2_chg_q <= p2_chg_d;
      end
   end

   assign P1_IN  = p1_in_q;
   assign P2_IN  = p2_in_q;
   assign P1_CHG = p1_chg_q;
   assign P2_CHG = p2_chg_q;

endmodule

// File: tb/tb_input_debounce.sv
// -----------------------------------------------------------------------------
// tb_input_debounce
// Directed bench for input_debounce. "dut" runs with PRESCALE=4, DB_COUNT=3;
// "dut_fast" runs with PRESCALE=1, DB_COUNT=1. Both share clock and reset.
// Edge numbering: e1 is the first rising edge after RESET is released.
// With PRESCALE=4 the ticks fall on e4, e8, e12; raw held from release is
// synchronized after e2, so a change is accepted at e12 and shown after e13.
// -----------------------------------------------------------------------------
module tb_input_debounce;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] p1_raw = '0, p2_raw = '0, q1_raw = '0, q2_raw = '0;
   logic [9:0] p1_in, p2_in, q1_in, q2_in;
   logic       p1_chg, p2_chg, q1_chg, q2_chg;

   int checks = 0;
   int errors = 0;
   int p1_cnt = 0, p2_cnt = 0, q1_cnt = 0, q2_cnt = 0;

   always #5 clk = ~clk;

   input_debounce #(.PRESCALE(4), .DB_COUNT(3)) dut (
      .CLK_24M (clk),
      .RESET   (rst),
      .P1_RAW  (p1_raw),
      .P2_RAW  (p2_raw),
      .P1_IN   (p1_in),
      .P2_IN   (p2_in),
      .P1_CHG  (p1_chg),
      .P2_CHG  (p2_chg)
   );

   input_debounce #(.PRESCALE(1), .DB_COUNT(1)) dut_fast (
      .CLK_24M (clk),
      .RESET   (rst),
      .P1_RAW  (q1_raw),
      .P2_RAW  (q2_raw),
      .P1_IN   (q1_in),
      .P2_IN   (q2_in),
      .P1_CHG  (q1_chg),
      .P2_CHG  (q2_chg)
   );

   // Change pulses last one full cycle, so a falling-edge sample sees each once.
   always @(negedge clk) begin
      if (rst) begin
         p1_cnt = 0; p2_cnt = 0; q1_cnt = 0; q2_cnt = 0;
      end else begin
         if (p1_chg) p1_cnt++;
         if (p2_chg) p2_cnt++;
         if (q1_chg) q1_cnt++;
         if (q2_chg) q2_cnt++;
      end
   end

   task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Apply raw values under reset, then release on a falling edge.
   task automatic do_reset(input logic [9:0] a, input logic [9:0] b,
                           input logic [9:0] c, input logic [9:0] d);
      @(negedge clk);
      rst = 1'b1;
      p1_raw = a; p2_raw = b; q1_raw = c; q2_raw = d;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Reset with all raw pins low: outputs must hold the idle value.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rst_p1_in", p1_in, 10'h3FF);
         check("rst_p2_in", p2_in, 10'h3FF);
         check("rst_chg", 10'({p1_chg, p2_chg, q1_chg, q2_chg}), 10'h0);
      end
      p1_raw = '1; p2_raw = '1; q1_raw = '1; q2_raw = '1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         edges(1);
         check("tick", 10'(dut.tick), 10'((k % 4) == 3));
      end
      check("idle_p1_in", p1_in, 10'h3FF);

      // Press: button A on player 1.
      do_reset(10'h3EF, 10'h3FF, 10'h3FF, 10'h3FF);
      edges(12);
      check("press_before", p1_in, 10'h3FF);
      edges(1);
      check("press_p1_in", p1_in, 10'h3EF);
      check("press_p1_chg", 10'(p1_chg), 10'h1);
      check("press_p2_in", p2_in, 10'h3FF);
      edges(1);
      check("press_chg_end", 10'(p1_chg), 10'h0);
      edges(20);
      check("press_p1_cnt", 10'(p1_cnt), 10'd1);
      check("press_p2_cnt", 10'(p2_cnt), 10'd0);

      // Glitch: player-2 start low across two ticks only.
      do_reset(10'h3FF, 10'h2FF, 10'h3FF, 10'h3FF);
      edges(8);
      p2_raw = 10'h3FF;
      edges(30);
      check("glitch_p2_in", p2_in, 10'h3FF);
      check("glitch_p2_cnt", 10'(p2_cnt), 10'd0);

      // Opposing up+down held together.
      do_reset(10'h3FC, 10'h3FF, 10'h3FF, 10'h3FF);
      edges(13);
`ifdef INPUT_SOCD_FILTER_EN
      check("socd_p1_in", p1_in, 10'h3FF);
      edges(20);
      check("socd_p1_cnt", 10'(p1_cnt), 10'd0);
`else
      check("socd_p1_in", p1_in, 10'h3FC);
      edges(20);
      check("socd_p1_cnt", 10'(p1_cnt), 10'd1);
`endif

      // Reset during a partial count must discard progress.
      do_reset(10'h3FE, 10'h3FF, 10'h3FF, 10'h3FF);
      edges(8);
      check("mid_before", p1_in, 10'h3FF);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_in_reset", p1_in, 10'h3FF);
      rst = 1'b0;
      edges(12);
      check("mid_after12", p1_in, 10'h3FF);
      check("mid_no_chg", 10'(p1_cnt), 10'd0);
      edges(1);
      check("mid_after13", p1_in, 10'h3FE);
      check("mid_chg", 10'(p1_chg), 10'h1);

      // Both players together, plus the fast instance.
      do_reset(10'h3DF, 10'h3BF, 10'h1FF, 10'h3F7);
      edges(3);
      check("fast_before", q1_in, 10'h3FF);
      edges(1);
      check("fast_q1_in", q1_in, 10'h1FF);
      check("fast_q2_in", q2_in, 10'h3F7);
      check("fast_chg", 10'({q1_chg, q2_chg}), 10'h3);
      edges(8);
      check("both_before", 10'({p1_in == 10'h3FF, p2_in == 10'h3FF}), 10'h3);
      edges(1);
      check("both_p1_in", p1_in, 10'h3DF);
      check("both_p2_in", p2_in, 10'h3BF);
      check("both_chg", 10'({p1_chg, p2_chg}), 10'h3);
      edges(10);
      check("both_cnt", 10'({p1_cnt[3:0], p2_cnt[3:0]}), 10'h11);
      check("fast_cnt", 10'({q1_cnt[3:0], q2_cnt[3:0]}), 10'h11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
